// File: rtl/dmem_mmio_bridge.sv
// M-stage data-memory decoder: RAM passthrough plus a 16-word MMIO window
// holding an LED register, a free-running cycle counter and a byte TX FIFO.
module dmem_mmio_bridge #(
  parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
  parameter int          RAM_ADDR_W = 12,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address_dmem,
  input  logic [31:0]           data,
  input  logic                  wren,
  output logic [31:0]           q_dmem,
  output logic [RAM_ADDR_W-1:0] ram_address,
  output logic [31:0]           ram_data,
  output logic                  ram_wren,
  input  logic [31:0]           ram_q,
  output logic [15:0]           led,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic             mmio_hit_s;
  logic [3:0]       offset_s;
  logic             wr_led_s;
  logic             wr_cycle_s;
  logic             push_req_s;
  logic             push_ok_s;
  logic             pop_s;
  logic             ovf_clr_s;
  logic             empty_s;
  logic             full_s;

  logic [15:0]      led_r;
  logic [31:0]      cycle_r;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;

  assign mmio_hit_s  = (address_dmem[31:4] == MMIO_BASE[31:4]);
  assign offset_s    = address_dmem[3:0];
  assign ram_address = address_dmem[RAM_ADDR_W-1:0];
  assign ram_data    = data;
  assign ram_wren    = wren & ~mmio_hit_s;

  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign full_s   = (count_r == DEPTH_C);
  assign tx_valid = ~empty_s;
  assign tx_data  = mem_r[rd_ptr_r];
  assign led      = led_r;

  // MMIO write strobes and FIFO handshake decode
  always_comb begin
    wr_led_s   = mmio_hit_s & wren & (offset_s == 4'd0);
    wr_cycle_s = mmio_hit_s & wren & (offset_s == 4'd1);
    push_req_s = mmio_hit_s & wren & (offset_s == 4'd2);
    ovf_clr_s  = mmio_hit_s & wren & (offset_s == 4'd3) & data[2];
    pop_s      = tx_valid & tx_ready;
    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    push_ok_s  = push_req_s & (~full_s | pop_s);
  end

  // Combinational load mux: MMIO registers on a window hit, RAM otherwise
  always_comb begin
    q_dmem = 32'h0000_0000;
    if (mmio_hit_s) begin
      case (offset_s)
        4'd0:    q_dmem = {16'h0000, led_r};
        4'd1:    q_dmem = cycle_r;
        4'd2:    q_dmem = {{(32-CNT_W){1'b0}}, count_r};
        4'd3:    q_dmem = {29'h0000_0000, overflow_r, full_s, empty_s};
        default: q_dmem = 32'h0000_0000;
      endcase
    end else begin
      q_dmem = ram_q;
    end
  end

  // LED register, cycle counter and sticky overflow flag
  always_ff @(posedge clock) begin
    if (reset) begin
      led_r      <= 16'h0000;
      cycle_r    <= 32'h0000_0000;
      overflow_r <= 1'b0;
    end else begin
      if (wr_led_s) begin
        led_r <= data[15:0];
      end
      cycle_r <= wr_cycle_s ? data : (cycle_r + 32'd1);
      if (push_req_s & ~push_ok_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // TX FIFO storage, pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= data[7:0];
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: RAM model, MMIO register checks and a
// byte scoreboard on the TX port.
module tb_dmem_mmio_bridge;
  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [11:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] ram_mem [0:4095];
  logic [7:0]  exp_q [$];

  dmem_mmio_bridge #(
    .MMIO_BASE  (32'h0000_F000),
    .RAM_ADDR_W (12),
    .FIFO_DEPTH (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .led          (led),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural data RAM: asynchronous read, write on the rising edge
  assign ram_q = ram_mem[ram_address];
  always @(posedge clock) begin
    if (ram_wren === 1'b1) ram_mem[ram_address] <= ram_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    address_dmem = a;
    data         = d;
    wren         = we;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 32'h0, 1'b0);
    @(negedge clock);
    chk(tag, q_dmem, exp);
    tick();
  endtask

  // TX scoreboard: every handshake must match the oldest expected byte
  always @(negedge clock) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("tx_unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("tx_byte", {24'h0, tx_data}, {24'h0, e});
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = 32'h0;
    reset    = 1'b1;
    tx_ready = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    tick();
    @(negedge clock);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    tick();

    // counter: 0 in the first cycle after reset, 10 ten cycles later
    reset = 1'b0;
    drive(32'h0000_F001, 32'h0, 1'b0);
    @(negedge clock);
    chk("cycle_0", q_dmem, 32'd0);
    repeat (10) tick();
    @(negedge clock);
    chk("cycle_10", q_dmem, 32'd10);
    tick();
    read_chk("status_reset", 32'h0000_F003, 32'h1);

    // RAM passthrough
    drive(32'h0000_0005, 32'hDEAD_BEEF, 1'b1);
    @(negedge clock);
    chk("ram_wren_store", {31'h0, ram_wren}, 32'h1);
    chk("ram_address", {20'h0, ram_address}, 32'h5);
    chk("ram_data", ram_data, 32'hDEAD_BEEF);
    tick();
    drive(32'h0000_0005, 32'h0, 1'b0);
    @(negedge clock);
    chk("ram_wren_load", {31'h0, ram_wren}, 32'h0);
    chk("ram_load", q_dmem, 32'hDEAD_BEEF);
    tick();

    // LED
    drive(32'h0000_F000, 32'h1234_ABCD, 1'b1);
    @(negedge clock);
    chk("mmio_no_ram_wren", {31'h0, ram_wren}, 32'h0);
    tick();
    drive(32'h0000_F000, 32'h0, 1'b0);
    @(negedge clock);
    chk("led_value", {16'h0, led}, 32'h0000_ABCD);
    chk("led_read", q_dmem, 32'h0000_ABCD);
    tick();
    drive(32'h0000_F005, 32'hFFFF_FFFF, 1'b1);
    tick();
    read_chk("unmapped_read", 32'h0000_F005, 32'h0);

    // counter load and wrap
    drive(32'h0000_F001, 32'hFFFF_FFFE, 1'b1);
    tick();
    read_chk("cycle_load", 32'h0000_F001, 32'hFFFF_FFFE);
    read_chk("cycle_max", 32'h0000_F001, 32'hFFFF_FFFF);
    read_chk("cycle_wrap", 32'h0000_F001, 32'h0);

    // FIFO fill with consumer stalled
    for (int i = 0; i < 8; i++) begin
      drive(32'h0000_F002, 32'h41 + i, 1'b1);
      exp_q.push_back(8'(8'h41 + i));
      tick();
    end
    read_chk("fifo_count_full", 32'h0000_F002, 32'd8);
    read_chk("status_full", 32'h0000_F003, 32'h2);
    drive(32'h0000_F002, 32'h49, 1'b1);
    tick();
    read_chk("status_overflow", 32'h0000_F003, 32'h6);
    drive(32'h0000_F003, 32'h3, 1'b1);
    tick();
    read_chk("status_no_clear", 32'h0000_F003, 32'h6);

    // drain: one byte per cycle for eight cycles
    drive(32'h0000_F002, 32'h0, 1'b0);
    tx_ready = 1'b1;
    repeat (8) tick();
    @(negedge clock);
    chk("drain_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_count", q_dmem, 32'd0);
    tick();
    tx_ready = 1'b0;
    read_chk("status_empty_ovf", 32'h0000_F003, 32'h5);
    drive(32'h0000_F003, 32'h4, 1'b1);
    tick();
    read_chk("status_w1c", 32'h0000_F003, 32'h1);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      drive(32'h0000_F002, 32'h61 + i, 1'b1);
      exp_q.push_back(8'(8'h61 + i));
      tick();
    end
    tx_ready = 1'b1;
    drive(32'h0000_F002, 32'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    tick();
    tx_ready = 1'b0;
    read_chk("pushpop_count", 32'h0000_F002, 32'd8);
    read_chk("pushpop_status", 32'h0000_F003, 32'h2);
    tx_ready = 1'b1;
    drive(32'h0000_F002, 32'h0, 1'b0);
    repeat (8) tick();
    @(negedge clock);
    chk("pushpop_drained", {31'h0, tx_valid}, 32'h0);
    chk("pushpop_queue", 32'(exp_q.size()), 32'd0);
    tick();
    tx_ready = 1'b0;

    // reset mid-operation: 3 bytes queued, LED all ones, overflow set
    for (int i = 0; i < 9; i++) begin
      drive(32'h0000_F002, 32'h30 + i, 1'b1);
      if (i < 8) exp_q.push_back(8'(8'h30 + i));
      tick();
    end
    drive(32'h0000_F000, 32'h0000_FFFF, 1'b1);
    tx_ready = 1'b1;
    repeat (5) tick();
    tx_ready = 1'b0;
    read_chk("pre_rst_count", 32'h0000_F002, 32'd3);
    read_chk("pre_rst_status", 32'h0000_F003, 32'h4);
    chk("pre_rst_led", {16'h0, led}, 32'h0000_FFFF);
    reset = 1'b1;
    drive(32'h0000_F000, 32'h0000_5555, 1'b1);
    tick();
    reset = 1'b0;
    exp_q.delete();
    drive(32'h0000_F001, 32'h0, 1'b0);
    @(negedge clock);
    chk("mid_rst_cycle0", q_dmem, 32'd0);
    chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_led", {16'h0, led}, 32'h0);
    tick();
    read_chk("mid_rst_status", 32'h0000_F003, 32'h1);
    read_chk("mid_rst_cycle2", 32'h0000_F001, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
